wbu: RTL and testbench
======================

Name: wbu

Overview:
- Writeback unit for the RV64 core; sits directly upstream of the general purpose register file and drives its write port (rd, rd_w_en, rd_idx_0, x_rd).
- Accepts one retiring instruction per handshake from the LSU/EXU stage.
- For loads, waits for the memory read response, then selects, aligns and sign/zero-extends the data.
- Commits one instruction per cycle maximum and keeps the retired-instruction counter.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; state is reset on a rising clk edge while rst==0.
- in_valid  in  1  upstream holds a valid retiring instruction.
- in_ready  out  1  wbu accepts this cycle; fire = in_valid & in_ready.
- in_pc  in  XLEN  pc of the instruction.
- in_rd  in  5  destination register index.
- in_rd_w_en  in  1  instruction writes rd.
- in_is_load  in  1  result comes from memory.
- in_load_op  in  3  funct3: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
- in_addr_lo  in  3  byte offset of the load address within the 8-byte word.
- in_alu_res  in  XLEN  result for non-load instructions.
- mem_rvalid  in  1  memory read data valid; one pulse per load.
- mem_rdata  in  XLEN  raw 8-byte-aligned read word.
- wb_stall  in  1  holds commit (debug/difftest).
- rd  out  5  to gpr.
- rd_w_en  out  1  to gpr.
- rd_idx_0  out  1  to gpr; high when rd==0.
- x_rd  out  XLEN  to gpr.
- commit_valid  out  1  an instruction retires this cycle.
- commit_pc  out  XLEN  pc of the retiring instruction.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Single-entry buffer with states IDLE, WAIT_MEM and HOLD.
  - The entry registers pc, rd, rd_w_en, load_op, addr_lo and result; all are reset to 0.
- Reset (rst==0 at a clk edge):
  - state=IDLE, instret=0, all entry registers=0.
  - Outputs after reset: rd_w_en=0, commit_valid=0, in_ready=1, rd=0, rd_idx_0=1, x_rd=0, commit_pc=0.
  - Any in-flight load is dropped, and a later mem_rvalid for it is ignored because state is IDLE.
- Transitions:
  - IDLE + fire with in_is_load=0: capture the entry with result=in_alu_res, go to HOLD.
  - IDLE + fire with in_is_load=1: capture the entry, go to WAIT_MEM.
  - WAIT_MEM + mem_rvalid: result = load_extend(mem_rdata, load_op, addr_lo), go to HOLD.
  - WAIT_MEM without mem_rvalid: stay.
  - HOLD: commit_fire = ~wb_stall.
    - On commit_fire with a simultaneous fire, reload the entry per the IDLE rules (HOLD or WAIT_MEM).
    - On commit_fire with no fire, go to IDLE.
    - Without commit_fire (wb_stall=1), stay.
- Combinational handshake and write port:
  - in_ready = (state==IDLE) | (state==HOLD & ~wb_stall).
  - This gives back-to-back ALU throughput of 1 per cycle.
- Commit outputs (combinational from entry registers):
  - commit_valid = commit_fire; commit_pc = entry pc.
  - rd = entry rd; rd_idx_0 = (entry rd==0); x_rd = entry result.
  - rd_w_en = commit_fire & entry rd_w_en & (entry rd!=0).
- Latency:
  - ALU op: commits the cycle after fire.
  - Load: commits the cycle after mem_rvalid (minimum 2 cycles after fire).
- instret increments by 1 on every commit_fire and wraps modulo 2^CNT_W.
- Load extension:
  - Byte lane = addr_lo. LB/LBU use data[8*addr_lo+:8]; LH/LHU use half lane addr_lo[2:1]; LW/LWU use word lane addr_lo[2].
  - LD uses the full word; funct3 111 is treated as LD.
  - Signed ops sign-extend to XLEN; U ops zero-extend.
  - Misaligned addr_lo bits below the access size are ignored (truncated to alignment).
- mem_rvalid outside WAIT_MEM is ignored.
- in_valid while in_ready=0 must be held stable by upstream; wbu does not capture it.
- wb_stall=1 in WAIT_MEM has no effect until HOLD.

Decomposition:
- Shared package wbu_pkg holds:
  - load_op encodings (LB..LWU);
  - state enum {IDLE=2'd0, WAIT_MEM=2'd1, HOLD=2'd2};
  - XLEN default.
- One combinational sub-module, load_extend, takes (rdata, load_op, addr_lo) and returns the extended XLEN value; it is reused by the difftest model.

Test Plan:
- Reset: hold rst=0 for 2 cycles, mid-load in WAIT_MEM -> rd_w_en=0, instret=0, in_ready=1; a mem_rvalid pulse after release produces no commit.
- Back-to-back ALU ops rd=5 (0x11), rd=6 (0x22), rd=0 (0x33), wb_stall=0:
  - commits on consecutive cycles; rd_w_en=1,1,0; rd_idx_0=0,0,1; instret=3.
- LB, addr_lo=3, mem_rdata=0x0000_0000_8000_0000, rvalid after 4 cycles:
  - x_rd=0xFFFF_FFFF_FFFF_FF80 one cycle after rvalid; LBU with the same inputs -> 0x80.
- LH addr_lo=6 with mem_rdata=0x8001_0000_0000_0000 -> 0xFFFF_FFFF_FFFF_8001; LWU addr_lo=4 -> 0x8001_0000.
- wb_stall=1 for 3 cycles while in HOLD with in_valid=1:
  - in_ready=0 and no commit; after release, commit then accept the next instruction in the same cycle; pc ordering preserved.
- mem_rvalid while in IDLE or HOLD -> ignored, entry result unchanged; instret counts wrap from 2^CNT_W-1 to 0 (force via CNT_W=4: 16 commits -> 0).

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared definitions for the writeback unit: load funct3 encodings,
// buffer state encoding and the default datapath width.
package wbu_pkg;

    localparam int unsigned XLEN_DEF = 64;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LD  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        HOLD     = 2'd2
    } state_t;

endpackage

// File: rtl/wbu_load_extend.sv
// Selects the addressed lane of an 8-byte read word and sign/zero-extends it
// according to the load funct3; low address bits below the access size are ignored.
module load_extend
    import wbu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      load_op,
    input  logic [2:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] word_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = rdata[{addr_lo[2:1], 4'b0000} +: 16];
        word_lane = rdata[{addr_lo[2], 5'b00000} +: 32];
    end

    always_comb begin
        data = rdata;
        case (load_op)
            OP_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            OP_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
            OP_LW:   data = {{(XLEN-32){word_lane[31]}}, word_lane};
            OP_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
            OP_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
            OP_LWU:  data = {{(XLEN-32){1'b0}}, word_lane};
            OP_LD:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wbu.sv
// Writeback unit: single-entry buffer between the LSU/EXU stage and the GPR
// write port; waits for load data, commits at most one instruction per cycle.
module wbu
    import wbu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_w_en,
    input  logic             in_is_load,
    input  logic [2:0]       in_load_op,
    input  logic [2:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_alu_res,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             wb_stall,
    output logic [4:0]       rd,
    output logic             rd_w_en,
    output logic             rd_idx_0,
    output logic [XLEN-1:0]  x_rd,
    output logic             commit_valid,
    output logic [XLEN-1:0]  commit_pc,
    output logic [CNT_W-1:0] instret
);

    state_t state_q, state_d;

    logic [XLEN-1:0]  ent_pc;
    logic [4:0]       ent_rd;
    logic             ent_rd_w_en;
    logic [2:0]       ent_load_op;
    logic [2:0]       ent_addr_lo;
    logic [XLEN-1:0]  ent_result;
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0]  load_data;

    logic fire;
    logic commit_fire;
    logic load_done;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata   (mem_rdata),
        .load_op (ent_load_op),
        .addr_lo (ent_addr_lo),
        .data    (load_data)
    );

    // A stalled HOLD entry blocks intake; an unstalled one frees the slot in the same cycle.
    always_comb begin
        commit_fire = (state_q == HOLD) & ~wb_stall;
        in_ready    = (state_q == IDLE) | commit_fire;
        fire        = in_valid & in_ready;
        load_done   = (state_q == WAIT_MEM) & mem_rvalid;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fire) state_d = in_is_load ? WAIT_MEM : HOLD;
            end
            WAIT_MEM: begin
                if (mem_rvalid) state_d = HOLD;
            end
            HOLD: begin
                if (commit_fire) begin
                    if (fire) state_d = in_is_load ? WAIT_MEM : HOLD;
                    else      state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ent_pc      <= '0;
            ent_rd      <= '0;
            ent_rd_w_en <= 1'b0;
            ent_load_op <= '0;
            ent_addr_lo <= '0;
            ent_result  <= '0;
            instret_q   <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                ent_pc      <= in_pc;
                ent_rd      <= in_rd;
                ent_rd_w_en <= in_rd_w_en;
                ent_load_op <= in_load_op;
                ent_addr_lo <= in_addr_lo;
                ent_result  <= in_alu_res;
            end else if (load_done) begin
                ent_result  <= load_data;
            end
            if (commit_fire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        commit_valid = commit_fire;
        commit_pc    = ent_pc;
        rd           = ent_rd;
        rd_idx_0     = (ent_rd == 5'd0);
        x_rd         = ent_result;
        rd_w_en      = commit_fire & ent_rd_w_en & (ent_rd != 5'd0);
        instret      = instret_q;
    end

endmodule

// File: tb/tb_wbu.sv
// Directed self-checking bench for wbu (instantiated with a 4-bit retire counter
// so that counter wrap-around is reachable).
module tb_wbu;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [4:0]       in_rd;
    logic             in_rd_w_en;
    logic             in_is_load;
    logic [2:0]       in_load_op;
    logic [2:0]       in_addr_lo;
    logic [XLEN-1:0]  in_alu_res;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;
    logic             wb_stall;
    logic [4:0]       rd;
    logic             rd_w_en;
    logic             rd_idx_0;
    logic [XLEN-1:0]  x_rd;
    logic             commit_valid;
    logic [XLEN-1:0]  commit_pc;
    logic [CNT_W-1:0] instret;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    wbu #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rd        (in_rd),
        .in_rd_w_en   (in_rd_w_en),
        .in_is_load   (in_is_load),
        .in_load_op   (in_load_op),
        .in_addr_lo   (in_addr_lo),
        .in_alu_res   (in_alu_res),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_stall     (wb_stall),
        .rd           (rd),
        .rd_w_en      (rd_w_en),
        .rd_idx_0     (rd_idx_0),
        .x_rd         (x_rd),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive_alu(input logic [XLEN-1:0] pc, input logic [4:0] r,
                             input logic [XLEN-1:0] res);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_pc      = pc;
        in_rd      = r;
        in_rd_w_en = 1'b1;
        in_alu_res = res;
        in_load_op = 3'b000;
        in_addr_lo = 3'b000;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rd_w_en = 1'b0;
        in_is_load = 1'b0; in_load_op = '0; in_addr_lo = '0; in_alu_res = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; wb_stall = 1'b0;
        tick; tick;
        rst = 1'b1;
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd3; in_rd_w_en = 1'b1; in_pc = 64'h40;
        tick;
        in_valid = 1'b0; in_is_load = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL rst_wait_ready: got %b required 0", in_ready);
        else pass_cnt++;
        rst = 1'b0;
        tick; tick;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({rd_w_en, commit_valid, in_ready, rd_idx_0} !== 4'b0011)
            $display("FAIL rst_flags: got %b required 0011", {rd_w_en, commit_valid, in_ready, rd_idx_0});
        else pass_cnt++;
        total_cnt++;
        if ({rd, x_rd, commit_pc, instret} !== '0)
            $display("FAIL rst_values: got rd=%h x_rd=%h pc=%h instret=%h required all 0", rd, x_rd, commit_pc, instret);
        else pass_cnt++;
        mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_9abc_def0;
        tick;
        mem_rvalid = 1'b0;
        #1;
        total_cnt++;
        if ({commit_valid, in_ready} !== 2'b01)
            $display("FAIL rst_stale_rvalid: got valid,ready=%b required 01", {commit_valid, in_ready});
        else pass_cnt++;
        tick;
        #1;
        total_cnt++;
        if ({commit_valid, instret} !== {1'b0, 4'd0})
            $display("FAIL rst_no_commit: got valid=%b instret=%0d required 0/0", commit_valid, instret);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [4:0]  rds [3] = '{5'd5, 5'd6, 5'd0};
        logic [63:0] res [3] = '{64'h11, 64'h22, 64'h33};
        logic        wen [3] = '{1'b1, 1'b1, 1'b0};
        logic        z   [3] = '{1'b0, 1'b0, 1'b1};
        tick;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_alu(64'h100 + 64'(4 * i), rds[i], res[i]);
            else in_valid = 1'b0;
            #1;
            if (i > 0) begin
                total_cnt++;
                if ({commit_valid, rd_w_en, rd_idx_0, rd, x_rd, commit_pc} !==
                    {1'b1, wen[i-1], z[i-1], rds[i-1], res[i-1], 64'h100 + 64'(4 * (i - 1))})
                    $display("FAIL b2b_commit%0d: got v=%b we=%b z=%b rd=%0d x=%h pc=%h required we=%b z=%b rd=%0d x=%h",
                             i - 1, commit_valid, rd_w_en, rd_idx_0, rd, x_rd, commit_pc,
                             wen[i-1], z[i-1], rds[i-1], res[i-1]);
                else pass_cnt++;
                exp_instret++;
            end
            if (i < 3) begin
                total_cnt++;
                if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b required 1", i, in_ready);
                else pass_cnt++;
            end
            tick;
        end
        #1;
        total_cnt++;
        if ({commit_valid, instret} !== {1'b0, 4'd3})
            $display("FAIL b2b_instret: got valid=%b instret=%0d required 0/3", commit_valid, instret);
        else pass_cnt++;
    endtask

    task automatic test_load;
        logic [2:0]  ops  [9] = '{3'b000, 3'b100, 3'b001, 3'b110, 3'b010, 3'b101, 3'b011, 3'b111, 3'b001};
        logic [2:0]  adr  [9] = '{3'd3, 3'd3, 3'd6, 3'd4, 3'd5, 3'd3, 3'd5, 3'd2, 3'd0};
        int          dly  [9] = '{4, 4, 1, 0, 2, 0, 1, 0, 3};
        logic [63:0] dat  [9] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                                  64'h8001_0000_0000_0000, 64'h8001_0000_0000_0000,
                                  64'hFFFF_FFFE_1234_5678, 64'h0000_0000_ABCD_1234,
                                  64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D,
                                  64'h1111_2222_3333_7FFF};
        logic [63:0] expv [9] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080,
                                  64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_8001_0000,
                                  64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_ABCD,
                                  64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D,
                                  64'h0000_0000_0000_7FFF};
        for (int i = 0; i < 9; i++) begin
            tick;
            in_valid = 1'b1; in_is_load = 1'b1; in_load_op = ops[i]; in_addr_lo = adr[i];
            in_pc = 64'h300 + 64'(4 * i); in_rd = 5'd10; in_rd_w_en = 1'b1; in_alu_res = 64'h5A5A;
            tick;
            in_valid = 1'b0; in_is_load = 1'b0;
            for (int d = 0; d < dly[i]; d++) begin
                #1;
                total_cnt++;
                if ({commit_valid, in_ready} !== 2'b00)
                    $display("FAIL load%0d_wait: got valid,ready=%b required 00", i, {commit_valid, in_ready});
                else pass_cnt++;
                tick;
            end
            mem_rvalid = 1'b1; mem_rdata = dat[i];
            tick;
            mem_rvalid = 1'b0; mem_rdata = '1;
            #1;
            total_cnt++;
            if ({commit_valid, rd_w_en, x_rd, commit_pc} !== {2'b11, expv[i], 64'h300 + 64'(4 * i)})
                $display("FAIL load%0d_data: got v=%b we=%b x_rd=%h pc=%h required x_rd=%h",
                         i, commit_valid, rd_w_en, x_rd, commit_pc, expv[i]);
            else pass_cnt++;
            exp_instret++;
            tick;
            #1;
            total_cnt++;
            if ({commit_valid, instret} !== {1'b0, exp_instret})
                $display("FAIL load%0d_instret: got v=%b instret=%0d required 0/%0d", i, commit_valid, instret, exp_instret);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall;
        tick;
        drive_alu(64'h200, 5'd7, 64'hAA);
        tick;
        wb_stall = 1'b1;
        drive_alu(64'h204, 5'd8, 64'hBB);
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if ({in_ready, commit_valid, rd_w_en, commit_pc} !== {3'b000, 64'h200})
                $display("FAIL stall_hold%0d: got rdy=%b v=%b we=%b pc=%h required 0/0/0/200",
                         c, in_ready, commit_valid, rd_w_en, commit_pc);
            else pass_cnt++;
            tick;
        end
        wb_stall = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, commit_valid, commit_pc, x_rd} !== {2'b11, 64'h200, 64'hAA})
            $display("FAIL stall_release: got rdy=%b v=%b pc=%h x=%h required 1/1/200/aa",
                     in_ready, commit_valid, commit_pc, x_rd);
        else pass_cnt++;
        exp_instret++;
        tick;
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if ({commit_valid, rd, commit_pc, x_rd} !== {1'b1, 5'd8, 64'h204, 64'hBB})
            $display("FAIL stall_next: got v=%b rd=%0d pc=%h x=%h required 1/8/204/bb",
                     commit_valid, rd, commit_pc, x_rd);
        else pass_cnt++;
        exp_instret++;
        tick;
        #1;
        total_cnt++;
        if ({commit_valid, instret} !== {1'b0, exp_instret})
            $display("FAIL stall_instret: got v=%b instret=%0d required 0/%0d", commit_valid, instret, exp_instret);
        else pass_cnt++;
    endtask

    task automatic test_ignore_rvalid;
        tick;
        mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_0000_1234;
        tick;
        mem_rvalid = 1'b0;
        #1;
        total_cnt++;
        if ({commit_valid, x_rd} !== {1'b0, 64'hBB})
            $display("FAIL idle_rvalid: got v=%b x_rd=%h required 0/bb", commit_valid, x_rd);
        else pass_cnt++;
        wb_stall = 1'b1;
        drive_alu(64'h400, 5'd9, 64'h55);
        tick;
        in_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = '1;
        tick;
        mem_rvalid = 1'b0;
        #1;
        total_cnt++;
        if ({commit_valid, in_ready, x_rd} !== {2'b00, 64'h55})
            $display("FAIL hold_rvalid: got v=%b rdy=%b x_rd=%h required 0/0/55", commit_valid, in_ready, x_rd);
        else pass_cnt++;
        wb_stall = 1'b0;
        #1;
        total_cnt++;
        if ({commit_valid, rd_w_en, x_rd} !== {2'b11, 64'h55})
            $display("FAIL hold_rvalid_commit: got v=%b we=%b x_rd=%h required 1/1/55", commit_valid, rd_w_en, x_rd);
        else pass_cnt++;
        exp_instret++;
    endtask

    task automatic test_wrap;
        tick;
        for (int i = 0; i < 20; i++) begin
            drive_alu(64'h1000 + 64'(4 * i), 5'((i % 31) + 1), 64'(i));
            #1;
            if (i > 0) begin
                total_cnt++;
                if ({commit_valid, instret} !== {1'b1, exp_instret})
                    $display("FAIL wrap_step%0d: got v=%b instret=%0d required 1/%0d", i, commit_valid, instret, exp_instret);
                else pass_cnt++;
                exp_instret++;
            end
            tick;
        end
        in_valid = 1'b0;
        #1;
        exp_instret++;
        tick;
        #1;
        total_cnt++;
        if ({commit_valid, instret} !== {1'b0, exp_instret})
            $display("FAIL wrap_final: got v=%b instret=%0d required 0/%0d", commit_valid, instret, exp_instret);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_load;
        test_stall;
        test_ignore_rvalid;
        test_wrap;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
